// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the operand beat; stage 2 registers the result and flags.
// Opcodes: ADD, SUB, SLL, SRL, AND, OR, XOR, and EQ on opcode 111.
// Define ALU_MUL_EN to turn opcode 111 into an iterative unsigned multiply.
// In that build, stage 1 holds a MUL beat for WIDTH shift-add edges before
// the beat may advance.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic             carry_o,
    output logic             zero_o
);

    // Shift amounts at or above this value flush the operand to zero.
    localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);

    // Returns {carry, result} for every opcode except the multiply.
    function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       op);
        logic [WIDTH:0] r;
        logic           big;
        big = ({1'b0, b} >= SHIFT_LIM);
        r   = '0;
        case (op)
            3'b000: r = {1'b0, a} + {1'b0, b};
            // The top bit of the widened difference is the borrow (a < b).
            3'b001: r = {1'b0, a} - {1'b0, b};
            3'b010: r[WIDTH-1:0] = big ? '0 : (a << b);
            3'b011: r[WIDTH-1:0] = big ? '0 : (a >> b);
            3'b100: r[WIDTH-1:0] = a & b;
            3'b101: r[WIDTH-1:0] = a | b;
            3'b110: r[WIDTH-1:0] = a ^ b;
            default: begin
`ifdef ALU_MUL_EN
                // The multiply result comes from the accumulator.
                r = '0;
`else
                r[0] = (a == b);
`endif
            end
        endcase
        return r;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [2:0]       op_p1;
    logic             op_done;
    logic             s1_advance;
    logic             accept;
    logic [WIDTH:0]   res_next;

    assign s1_advance = vld_p1 && op_done && (!valid_o || ready_i);
    assign ready_o    = !reset && (!vld_p1 || s1_advance);
    assign accept     = valid_i && ready_o;

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0]   mul_cnt;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_acc;
    logic               mul_busy;

    assign mul_busy = vld_p1 && (op_p1 == 3'b111) && !mul_done;
    assign op_done  = (op_p1 != 3'b111) || mul_done;

    // Shift-add multiplier: one partial product per edge while a MUL sits in stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt  <= '0;
            mul_done <= 1'b0;
            mul_acc  <= '0;
        end else if (accept) begin
            mul_cnt  <= '0;
            mul_done <= 1'b0;
            mul_acc  <= '0;
        end else if (mul_busy) begin
            mul_acc <= mul_acc + (b_p1[mul_cnt] ? ({{WIDTH{1'b0}}, a_p1} << mul_cnt) : '0);
            if (mul_cnt == CNT_W'(WIDTH - 1)) begin
                mul_cnt  <= '0;
                mul_done <= 1'b1;
            end else begin
                mul_cnt <= mul_cnt + 1'b1;
            end
        end
    end
`else
    assign op_done = 1'b1;
`endif

    // Select the stage-2 result: ALU function, or the finished product for MUL.
    always_comb begin
        res_next = alu_eval(a_p1, b_p1, op_p1);
`ifdef ALU_MUL_EN
        if (op_p1 == 3'b111) begin
            res_next = {|mul_acc[2*WIDTH-1:WIDTH], mul_acc[WIDTH-1:0]};
        end
`endif
    end

    // ---- stage 1: operand register ----
    // Track stage-1 occupancy: fill on input transfer, drain on advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s1_advance) begin
            vld_p1 <= 1'b0;
        end
    end

    // Capture the operand beat on input transfer; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1  <= a_i;
            b_p1  <= b_i;
            op_p1 <= op_i;
        end
    end

    // ---- stage 2: output register ----
    // Load the result on advance; hold it while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o <= 1'b0;
            alu_o   <= '0;
            carry_o <= 1'b0;
            zero_o  <= 1'b0;
        end else if (s1_advance) begin
            valid_o <= 1'b1;
            alu_o   <= res_next[WIDTH-1:0];
            carry_o <= res_next[WIDTH];
            zero_o  <= (res_next[WIDTH-1:0] == '0);
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8.
// Opcode 111 vectors follow ALU_MUL_EN (EQ without it, MUL with it).
module tb_alu_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic [2:0]       op_i = 3'b000;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [WIDTH-1:0] alu_o;
    logic             carry_o;
    logic             zero_o;

    int errors = 0;
    int checks = 0;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .op_i    (op_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .alu_o   (alu_o),
        .carry_o (carry_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Send one beat with ready_i high, wait for the result, check it and its latency.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_z,
                        input int exp_lat, input int exp_rlow);
        int lat;
        int rlow;
        a_i = a; b_i = b; op_i = op; valid_i = 1'b1;
        #1;
        chk({tag, "/ready"}, 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        rlow = 0;
        while (!valid_o && lat < 40) begin
            if (!ready_o) rlow++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/alu"}, 32'(alu_o), 32'(exp_res));
        chk({tag, "/carry"}, 32'(carry_o), 32'(exp_c));
        chk({tag, "/zero"}, 32'(zero_o), 32'(exp_z));
        chk({tag, "/rdy_low"}, 32'(rlow), 32'(exp_rlow));
        @(posedge clk); #1;
        chk({tag, "/drained"}, 32'(valid_o), 32'd0);
    endtask

    initial begin : main
        logic [7:0] got_q[$];
        logic       xfer_out;
        logic       xfer_in;
        logic [7:0] exp_bp [3];

        // Reset state while reset is held
        #2;
        chk("rst/valid_o", 32'(valid_o), 32'd0);
        chk("rst/alu_o", 32'(alu_o), 32'd0);
        chk("rst/carry_o", 32'(carry_o), 32'd0);
        chk("rst/zero_o", 32'(zero_o), 32'd0);
        chk("rst/ready_o", 32'(ready_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run1("add_f0_20", 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1, 1'b0, 1, 0);
        run1("sub_05_05", 8'h05, 8'h05, 3'b001, 8'h00, 1'b0, 1'b1, 1, 0);
        run1("sub_03_05", 8'h03, 8'h05, 3'b001, 8'hFE, 1'b1, 1'b0, 1, 0);
        run1("sll_81_1", 8'h81, 8'h01, 3'b010, 8'h02, 1'b0, 1'b0, 1, 0);
        run1("srl_80_9", 8'h80, 8'h09, 3'b011, 8'h00, 1'b0, 1'b1, 1, 0);
        run1("sll_01_7", 8'h01, 8'h07, 3'b010, 8'h80, 1'b0, 1'b0, 1, 0);
        run1("srl_f0_4", 8'hF0, 8'h04, 3'b011, 8'h0F, 1'b0, 1'b0, 1, 0);
        run1("and", 8'hCC, 8'hAA, 3'b100, 8'h88, 1'b0, 1'b0, 1, 0);
        run1("or", 8'hCC, 8'hAA, 3'b101, 8'hEE, 1'b0, 1'b0, 1, 0);
        run1("xor", 8'hCC, 8'hAA, 3'b110, 8'h66, 1'b0, 1'b0, 1, 0);
`ifdef ALU_MUL_EN
        run1("mul_0d_0b", 8'h0D, 8'h0B, 3'b111, 8'h8F, 1'b0, 1'b0, 9, 8);
        run1("mul_10_10", 8'h10, 8'h10, 3'b111, 8'h00, 1'b1, 1'b1, 9, 8);
`else
        run1("eq_3c_3c", 8'h3C, 8'h3C, 3'b111, 8'h01, 1'b0, 1'b0, 1, 0);
        run1("eq_3c_3d", 8'h3C, 8'h3D, 3'b111, 8'h00, 1'b0, 1'b1, 1, 0);
`endif

        // Backpressure: offer 1+1, 2+2, 3+3 with the consumer stalled
        ready_i = 1'b0;
        a_i = 8'd1; b_i = 8'd1; op_i = 3'b000; valid_i = 1'b1;
        #1;
        chk("bp/acc1", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        a_i = 8'd2; b_i = 8'd2;
        chk("bp/acc2", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        a_i = 8'd3; b_i = 8'd3;
        chk("bp/full", 32'(ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp/hold_valid", 32'(valid_o), 32'd1);
            chk("bp/hold_alu", 32'(alu_o), 32'h02);
            chk("bp/hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            xfer_out = valid_o && ready_i;
            xfer_in  = valid_i && ready_o;
            if (xfer_out) got_q.push_back(alu_o);
            @(posedge clk); #1;
            if (xfer_in) valid_i = 1'b0;
        end
        exp_bp[0] = 8'h02; exp_bp[1] = 8'h04; exp_bp[2] = 8'h06;
        chk("bp/count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp/order", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_bp[i]));
        end

        // Asynchronous reset during a stall with a result held at the output
        ready_i = 1'b0;
        a_i = 8'h11; b_i = 8'h22; op_i = 3'b000; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid/pre_alu", 32'(alu_o), 32'h33);
        #3 reset = 1'b1;
        #1;
        chk("rst_mid/valid_o", 32'(valid_o), 32'd0);
        chk("rst_mid/alu_o", 32'(alu_o), 32'd0);
        chk("rst_mid/carry_o", 32'(carry_o), 32'd0);
        chk("rst_mid/zero_o", 32'(zero_o), 32'd0);
        chk("rst_mid/ready_o", 32'(ready_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        run1("post_rst_add", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0, 1'b0, 1, 0);

`ifdef ALU_MUL_EN
        // Asynchronous reset in the middle of a multiply
        a_i = 8'h10; b_i = 8'h10; op_i = 3'b111; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mul/valid_o", 32'(valid_o), 32'd0);
        chk("rst_mul/alu_o", 32'(alu_o), 32'd0);
        chk("rst_mul/ready_o", 32'(ready_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run1("post_mul_rst_add", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0, 1'b0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
